// File: rtl/strip_frame_ctrl_if.sv
// Signal bundle linking the strip frame controller to its frame requesters,
// the pixel memory read port and the LED sender handshake.
interface strip_frame_ctrl_if;
  logic       frame_go;
  logic       refresh_en;
  logic       frame_busy;
  logic       frame_done;
  logic [7:0] pix_addr;
  logic [7:0] pix_blue;
  logic [7:0] pix_green;
  logic [7:0] pix_red;
  logic [1:0] led_type;
  logic [7:0] led_blue;
  logic [7:0] led_green;
  logic [7:0] led_red;
  logic       led_start;
  logic       led_busy;

  modport master (
    input  frame_go, refresh_en, pix_blue, pix_green, pix_red, led_busy,
    output frame_busy, frame_done, pix_addr, led_type, led_blue, led_green, led_red, led_start
  );

  modport slave (
    output frame_go, refresh_en, pix_blue, pix_green, pix_red, led_busy,
    input  frame_busy, frame_done, pix_addr, led_type, led_blue, led_green, led_red, led_start
  );
endinterface

// File: rtl/strip_frame_ctrl.sv
// Sequences one LED strip refresh: a START transfer, one LED transfer per pixel
// and a run of END transfers, triggered by request pulses or a periodic timer.
module strip_frame_ctrl #(
  parameter int NUM_LEDS       = 60,
  parameter int END_COUNT      = 4,
  parameter int REFRESH_CYCLES = 500000
) (
  input  logic                doled_clk,
  input  logic                doled_reset,
  strip_frame_ctrl_if.master  ctrl_io
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    S_ISSUE = 4'd1,
    S_WAIT  = 4'd2,
    FETCH   = 4'd3,
    CAPTURE = 4'd4,
    L_ISSUE = 4'd5,
    L_WAIT  = 4'd6,
    E_ISSUE = 4'd7,
    E_WAIT  = 4'd8,
    DONE    = 4'd9
  } state_e;

  localparam int              TW         = $clog2(REFRESH_CYCLES);
  localparam logic [7:0]      LAST_LED   = 8'(NUM_LEDS - 1);
  localparam logic [3:0]      LAST_END   = 4'(END_COUNT - 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(REFRESH_CYCLES - 1);

  state_e        state_q, state_d;
  logic          pending_q, pending_d;
  logic [7:0]    led_idx_q, led_idx_d;
  logic [3:0]    end_cnt_q, end_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          tick_s;
  logic          req_s;

  logic          led_start_q, led_start_d;
  logic          frame_busy_q, frame_busy_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    pix_addr_q, pix_addr_d;
  logic [1:0]    led_type_q, led_type_d;
  logic [7:0]    led_blue_q, led_blue_d;
  logic [7:0]    led_green_q, led_green_d;
  logic [7:0]    led_red_q, led_red_d;

  // State, bookkeeping and registered outputs
  always_ff @(posedge doled_clk or posedge doled_reset) begin
    if (doled_reset) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      led_idx_q    <= 8'd0;
      end_cnt_q    <= 4'd0;
      timer_q      <= '0;
      led_start_q  <= 1'b0;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      pix_addr_q   <= 8'd0;
      led_type_q   <= 2'd0;
      led_blue_q   <= 8'h00;
      led_green_q  <= 8'h00;
      led_red_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      led_idx_q    <= led_idx_d;
      end_cnt_q    <= end_cnt_d;
      timer_q      <= timer_d;
      led_start_q  <= led_start_d;
      frame_busy_q <= frame_busy_d;
      frame_done_q <= frame_done_d;
      pix_addr_q   <= pix_addr_d;
      led_type_q   <= led_type_d;
      led_blue_q   <= led_blue_d;
      led_green_q  <= led_green_d;
      led_red_q    <= led_red_d;
    end
  end

  // Next state, refresh timer and request merging
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    led_idx_d = led_idx_q;
    end_cnt_d = end_cnt_q;
    timer_d   = timer_q;
    tick_s    = 1'b0;
    req_s     = 1'b0;

    if (!ctrl_io.refresh_en) begin
      timer_d = '0;
    end else if (timer_q == TIMER_LAST) begin
      timer_d = '0;
      tick_s  = 1'b1;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    // A simultaneous pulse and timer expiry is one request.
    req_s = ctrl_io.frame_go | tick_s;
    if (req_s && (state_q != IDLE)) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    case (state_q)
      IDLE: begin
        if (req_s || pending_q) begin
          state_d   = S_ISSUE;
          pending_d = 1'b0;
          led_idx_d = 8'd0;
          end_cnt_d = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      S_ISSUE: begin
        if (ctrl_io.led_busy) state_d = S_WAIT;
        else                  state_d = S_ISSUE;
      end
      S_WAIT: begin
        if (!ctrl_io.led_busy) state_d = FETCH;
        else                   state_d = S_WAIT;
      end
      FETCH:   state_d = CAPTURE;
      CAPTURE: state_d = L_ISSUE;
      L_ISSUE: begin
        if (ctrl_io.led_busy) state_d = L_WAIT;
        else                  state_d = L_ISSUE;
      end
      L_WAIT: begin
        if (ctrl_io.led_busy) begin
          state_d = L_WAIT;
        end else if (led_idx_q == LAST_LED) begin
          state_d = E_ISSUE;
        end else begin
          led_idx_d = led_idx_q + 8'd1;
          state_d   = FETCH;
        end
      end
      E_ISSUE: begin
        if (ctrl_io.led_busy) state_d = E_WAIT;
        else                  state_d = E_ISSUE;
      end
      E_WAIT: begin
        if (ctrl_io.led_busy) begin
          state_d = E_WAIT;
        end else if (end_cnt_q == LAST_END) begin
          state_d = DONE;
        end else begin
          end_cnt_d = end_cnt_q + 4'd1;
          state_d   = E_ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values, decoded from the state being entered
  always_comb begin
    led_start_d  = (state_d == S_ISSUE) || (state_d == L_ISSUE) || (state_d == E_ISSUE);
    frame_busy_d = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
    pix_addr_d   = pix_addr_q;
    led_type_d   = led_type_q;
    led_blue_d   = led_blue_q;
    led_green_d  = led_green_q;
    led_red_d    = led_red_q;

    case (state_d)
      S_ISSUE: begin
        led_type_d  = 2'd0;
        led_blue_d  = 8'h00;
        led_green_d = 8'h00;
        led_red_d   = 8'h00;
      end
      // Address is presented throughout FETCH so read data is ready in CAPTURE.
      FETCH: pix_addr_d = led_idx_d;
      L_ISSUE: begin
        if (state_q == CAPTURE) begin
          led_type_d  = 2'd1;
          led_blue_d  = ctrl_io.pix_blue;
          led_green_d = ctrl_io.pix_green;
          led_red_d   = ctrl_io.pix_red;
        end else begin
          led_type_d  = led_type_q;
        end
      end
      E_ISSUE: begin
        led_type_d  = 2'd2;
        led_blue_d  = 8'hFF;
        led_green_d = 8'hFF;
        led_red_d   = 8'hFF;
      end
      default: pix_addr_d = pix_addr_q;
    endcase
  end

  assign ctrl_io.led_start  = led_start_q;
  assign ctrl_io.frame_busy = frame_busy_q;
  assign ctrl_io.frame_done = frame_done_q;
  assign ctrl_io.pix_addr   = pix_addr_q;
  assign ctrl_io.led_type   = led_type_q;
  assign ctrl_io.led_blue   = led_blue_q;
  assign ctrl_io.led_green  = led_green_q;
  assign ctrl_io.led_red    = led_red_q;

endmodule

// File: doc/strip_frame_ctrl.md
STRIP_FRAME_CTRL -- requirements
Module: strip_frame_ctrl

Interface
REQ-001 Parameter NUM_LEDS, default 60: LED modules per strip frame, range 1..256.
REQ-002 Parameter END_COUNT, default 4: END-type transfers appended after the last LED, range 1..15.
REQ-003 Parameter REFRESH_CYCLES, default 500000: auto-refresh period in clocks, minimum 2.
REQ-004 doled_clk  in  1  clock; all logic on rising edge.
REQ-005 doled_reset  in  1  reset, asynchronous, active-high.
REQ-006 frame_go  in  1  single-cycle request for one strip refresh.
REQ-007 refresh_en  in  1  level; enables the periodic auto-refresh timer.
REQ-008 frame_busy  out  1  high from frame acceptance until frame completion.
REQ-009 frame_done  out  1  one-cycle pulse when the final END transfer completes.
REQ-010 pix_addr  out  8  pixel memory read address, 0..NUM_LEDS-1.
REQ-011 pix_blue, pix_green, pix_red  in  8 each  pixel memory read data, valid one clock after pix_addr.
REQ-012 led_type  out  2  type to LED sender: 0 START, 1 LED, 2 END.
REQ-013 led_blue, led_green, led_red  out  8 each  color bytes to LED sender.
REQ-014 led_start  out  1  request to LED sender.
REQ-015 led_busy  in  1  LED sender busy.

Function
REQ-016 States: IDLE, S_ISSUE, S_WAIT, FETCH, CAPTURE, L_ISSUE, L_WAIT, E_ISSUE, E_WAIT, DONE.
REQ-017 IDLE: frame_go=1 or pending=1 or timer expiry -> S_ISSUE, frame_busy<=1, pending<=0, led_idx<=0, end_cnt<=0.
REQ-018 Sender handshake, every *_ISSUE state: led_start=1, led_type/colors held; stay until led_busy=1, then led_start<=0 and go to matching *_WAIT.
REQ-019 *_WAIT: led_type/colors held unchanged; stay while led_busy=1; exit on led_busy=0.
REQ-020 led_start never high in a cycle where a *_WAIT state was entered; at most one transfer in flight.
REQ-021 S_ISSUE: led_type=0, colors=0x00; S_WAIT exit -> FETCH.
REQ-022 FETCH: pix_addr<=led_idx -> CAPTURE.
REQ-023 CAPTURE: led_blue/green/red<=pix_blue/green/red, led_type<=1 -> L_ISSUE.
REQ-024 L_WAIT exit: led_idx==NUM_LEDS-1 -> E_ISSUE; else led_idx<=led_idx+1 -> FETCH.
REQ-025 E_ISSUE: led_type=2, colors=0xFF; E_WAIT exit: end_cnt==END_COUNT-1 -> DONE; else end_cnt+1 -> E_ISSUE.
REQ-026 DONE: frame_done=1 for exactly one cycle, frame_busy<=0 -> IDLE.
REQ-027 Frame totals: exactly 1 START, NUM_LEDS LED (addresses ascending 0..NUM_LEDS-1), END_COUNT END transfers.
REQ-028 frame_go while frame_busy=1: set pending; multiple requests collapse to one; pending frame begins on IDLE exit the cycle after DONE.
REQ-029 Refresh timer: counts when refresh_en=1, clears when refresh_en=0; on reaching REFRESH_CYCLES-1 it wraps to 0 and issues a request (same as frame_go, including pending rules).
REQ-030 frame_go and timer expiry in the same cycle: one request only.
REQ-031 led_busy already high in IDLE: frame still accepted; S_ISSUE waits for completion of the foreign transfer naturally via REQ-018/019 (no early advance on stale busy is required beyond that).
REQ-032 led_idx 8 bits; no wrap beyond NUM_LEDS-1.

Reset
REQ-033 doled_reset=1 at any time, including mid-transfer: state IDLE, led_start=0, frame_busy=0, frame_done=0, pending=0, led_idx=0, end_cnt=0, timer=0, pix_addr=0, led_type=0, colors=0x00.
REQ-034 After reset release, no transfer starts without a new request.

Verification (NUM_LEDS=3, END_COUNT=2, sender model: busy 1 clock after start, held 10 clocks)
REQ-035 frame_go pulse, pixels {0x10,0x20,0x30},{0x11,0x21,0x31},{0x12,0x22,0x32} -> sender sees types 0,1,1,1,2,2; LED colors in order; START all 0x00, END all 0xFF; one frame_done.
REQ-036 frame_go pulsed 3 times during a frame -> exactly one additional frame after DONE, then IDLE.
REQ-037 refresh_en=1, REFRESH_CYCLES=200 -> frames begin at cycles 200 and 400 after enable; refresh_en=0 -> no further frames.
REQ-038 doled_reset asserted during second LED transfer -> all outputs at REQ-033 values immediately; no frame_done; idle until next frame_go.
REQ-039 Sender busy delayed 5 clocks after start -> led_start held high 5 clocks, colors/type stable until busy falls; no duplicate transfer.
REQ-040 frame_go coincident with timer expiry while idle -> single frame, pending=0.
